lbmem_unpack: RTL and testbench

- Consumer end of the line-buffer memory output interface.
- Accepts the unthrottled 8-bit sample stream (rdata qualified by valid) and packs PACK samples per output word.
- Tags the word that closes each LINE_LEN-sample line, and presents words downstream over a ready/valid handshake through a small word FIFO.
- The source cannot be stalled, so FIFO overrun is detected and flagged sticky rather than back-pressured.

---
 rtl/lbmem_unpack_pkg.sv | 25 ++
 rtl/lbmem_word_fifo.sv | 75 +++++++
 rtl/lbmem_unpack.sv | 105 ++++++++++
 tb/tb_lbmem_unpack.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbmem_unpack_pkg.sv
// rtl/lbmem_unpack_pkg.sv - shared defaults, derived widths and word type for lbmem_unpack
// Word entries carry the end-of-line tag alongside the packed samples.
package lbmem_unpack_pkg;

   localparam int LWIDTH_DEF     = 8;
   localparam int PACK_DEF       = 4;
   localparam int LINE_LEN_DEF   = 64;
   localparam int FIFO_DEPTH_DEF = 4;

   // Widths never collapse to zero, so LINE_LEN = 1 still yields a legal counter
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int WWIDTH = LWIDTH_DEF * PACK_DEF;
   localparam int LANE_W = idx_bits(PACK_DEF);
   localparam int POS_W  = idx_bits(LINE_LEN_DEF);
   localparam int LVL_W  = $clog2(FIFO_DEPTH_DEF) + 1;

   typedef struct packed {
      logic              last;
      logic [WWIDTH-1:0] data;
   } word_t;

endpackage

// File: rtl/lbmem_word_fifo.sv
// rtl/lbmem_word_fifo.sv - synchronous word FIFO with level, full/empty and head hold
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module lbmem_word_fifo
   import lbmem_unpack_pkg::*;
#(
   parameter type entry_t = word_t,
   parameter int  DEPTH   = FIFO_DEPTH_DEF,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   output entry_t        head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] level
);

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   entry_t          hold_q, hold_d;
   logic [AW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign level = cnt_q;
   // Once drained, the head keeps showing the last word handed downstream
   assign head  = empty ? hold_q : mem_q[rptr_q];

   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      if (do_push) begin
         mem_d[wptr_q] = push_data;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
         hold_d = mem_q[rptr_q];
         rptr_d = rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '{default: '0};
         hold_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         hold_q <= hold_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/lbmem_unpack.sv
// rtl/lbmem_unpack.sv - packs the unthrottled line-buffer sample stream into tagged words
// The source cannot stall, so a word arriving at a full FIFO is dropped and flagged sticky.
module lbmem_unpack
   import lbmem_unpack_pkg::*;
#(
   parameter int LWIDTH     = LWIDTH_DEF,
   parameter int PACK       = PACK_DEF,
   parameter int LINE_LEN   = LINE_LEN_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                           CLK,
   input  logic                           ASYNCRESET,
   input  logic [LWIDTH-1:0]              rdata,
   input  logic                           valid,
   output logic [LWIDTH*PACK-1:0]         out_data,
   output logic                           out_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           overflow,
   output logic [$clog2(FIFO_DEPTH):0]    level
);

   localparam int WW = LWIDTH * PACK;
   localparam int LW = idx_bits(PACK);
   localparam int PW = idx_bits(LINE_LEN);

   typedef struct packed {
      logic          last;
      logic [WW-1:0] data;
   } entry_t;

   logic [LW-1:0] lane_q, lane_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [WW-1:0] pack_q, pack_d;
   logic          ovf_q, ovf_d;
   logic [WW-1:0] merged;
   logic          line_end, lane_end, word_done;
   logic          fifo_full, fifo_empty, fifo_pop;
   entry_t        push_word, head_word;

   assign fifo_pop = out_ready & ~fifo_empty;

   always_comb begin
      lane_d   = lane_q;
      pos_d    = pos_q;
      pack_d   = pack_q;
      ovf_d    = ovf_q;
      merged   = pack_q;
      for (int l = 0; l < PACK; l++) begin
         if (lane_q == LW'(l)) merged[l*LWIDTH +: LWIDTH] = rdata;
      end
      line_end  = (pos_q == PW'(LINE_LEN - 1));
      lane_end  = (lane_q == LW'(PACK - 1));
      word_done = valid & (line_end | lane_end);
      if (valid) begin
         if (word_done) begin
            lane_d = '0;
            pack_d = '0;
         end else begin
            lane_d = lane_q + LW'(1);
            pack_d = merged;
         end
         pos_d = line_end ? '0 : pos_q + PW'(1);
      end
      // Pack register is cleared after each word, so short end-of-line words have zero upper lanes
      push_word.last = line_end;
      push_word.data = merged;
      if (word_done & fifo_full & ~fifo_pop) ovf_d = 1'b1;
   end

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         lane_q <= '0;
         pos_q  <= '0;
         pack_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         lane_q <= lane_d;
         pos_q  <= pos_d;
         pack_q <= pack_d;
         ovf_q  <= ovf_d;
      end
   end

   lbmem_word_fifo #(
      .entry_t (entry_t),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (ASYNCRESET),
      .push      (word_done),
      .push_data (push_word),
      .pop       (fifo_pop),
      .head      (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   assign out_data  = head_word.data;
   assign out_last  = head_word.last;
   assign out_valid = ~fifo_empty;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_lbmem_unpack.sv
// tb/tb_lbmem_unpack.sv - self-checking bench for lbmem_unpack
// Instance a uses default LINE_LEN 64, instance b uses LINE_LEN 6; both see the same stream.
module tb_lbmem_unpack;

   logic        CLK = 1'b0;
   logic        ASYNCRESET = 1'b1;
   logic [7:0]  rdata = '0;
   logic        valid = 1'b0;
   logic        out_ready = 1'b0;

   logic [31:0] a_data, b_data;
   logic        a_last, b_last, a_valid, b_valid, a_ovf, b_ovf;
   logic [2:0]  a_level, b_level;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   lbmem_unpack dut_a (
      .CLK(CLK), .ASYNCRESET(ASYNCRESET), .rdata(rdata), .valid(valid),
      .out_data(a_data), .out_last(a_last), .out_valid(a_valid), .out_ready(out_ready),
      .overflow(a_ovf), .level(a_level)
   );

   lbmem_unpack #(.LINE_LEN(6)) dut_b (
      .CLK(CLK), .ASYNCRESET(ASYNCRESET), .rdata(rdata), .valid(valid),
      .out_data(b_data), .out_last(b_last), .out_valid(b_valid), .out_ready(out_ready),
      .overflow(b_ovf), .level(b_level)
   );

   // Reference model: samples collected per word, words held in plain queues
   int          m_pos [2];
   int          m_n   [2];
   logic [7:0]  m_samp [2][4];
   logic        m_ovf [2];
   logic [32:0] m_last_pop [2];
   logic [32:0] mq0[$];
   logic [32:0] mq1[$];

   function automatic int qsize(input int i);
      return (i == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [32:0] qhead(input int i);
      if (qsize(i) == 0) return m_last_pop[i];
      return (i == 0) ? mq0[0] : mq1[0];
   endfunction

   function automatic logic [31:0] seq_word(input int b);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(b + k);
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pos[i] = 0; m_n[i] = 0; m_ovf[i] = 1'b0; m_last_pop[i] = '0;
      end
      mq0.delete();
      mq1.delete();
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
      for (int i = 0; i < 2; i++) begin
         int          len;
         logic [31:0] w;
         len = (i == 0) ? 64 : 6;
         if (qsize(i) > 0 && r) begin
            if (i == 0) m_last_pop[0] = mq0.pop_front();
            else        m_last_pop[1] = mq1.pop_front();
         end
         if (v) begin
            m_samp[i][m_n[i]] = d;
            m_n[i]++;
            if (m_n[i] == 4 || m_pos[i] == len - 1) begin
               w = '0;
               for (int k = 0; k < m_n[i]; k++) w[8*k +: 8] = m_samp[i][k];
               if (qsize(i) < 4) begin
                  if (i == 0) mq0.push_back({m_pos[i] == len - 1, w});
                  else        mq1.push_back({m_pos[i] == len - 1, w});
               end else begin
                  m_ovf[i] = 1'b1;
               end
               m_n[i] = 0;
            end
            m_pos[i] = (m_pos[i] == len - 1) ? 0 : m_pos[i] + 1;
         end
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic r);
      valid = v; rdata = d; out_ready = r;
      @(posedge CLK);
      model_edge(v, d, r);
      #1;
   endtask

   task automatic do_reset();
      valid = 1'b0; out_ready = 1'b0; ASYNCRESET = 1'b1;
      @(posedge CLK);
      #1;
      ASYNCRESET = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", a_valid); end
      tests++; if (a_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", a_level); end
      tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", a_data); end
      tests++; if (a_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", a_last); end
      tests++; if (a_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
   endtask

   task automatic test_basic();
      do_reset();
      for (int s = 0; s < 3; s++) begin
         step(1'b1, 8'(s + 1), 1'b1);
         tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", a_valid); end
      end
      step(1'b1, 8'h04, 1'b1);
      tests++; if (a_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", a_valid); end
      tests++; if (a_data !== 32'h04030201) begin fails++; $display("FAIL basic_data: got %h want 04030201", a_data); end
      tests++; if (a_last !== 1'b0) begin fails++; $display("FAIL basic_last: got %b want 0", a_last); end
      step(1'b0, 8'h00, 1'b1);
      tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle: got %b want 0", a_valid); end
   endtask

   task automatic test_line_end();
      do_reset();
      for (int s = 0; s < 6; s++) begin
         step(1'b1, 8'(8'h10 + s), 1'b1);
         if (s == 3) begin
            tests++; if (b_data !== 32'h13121110 || b_last !== 1'b0 || b_valid !== 1'b1) begin
               fails++; $display("FAIL line_word0: got %b/%h/%b want 1/13121110/0", b_valid, b_data, b_last); end
         end
      end
      tests++; if (b_data !== 32'h00001514 || b_last !== 1'b1 || b_valid !== 1'b1) begin
         fails++; $display("FAIL line_word1: got %b/%h/%b want 1/00001514/1", b_valid, b_data, b_last); end
      for (int s = 0; s < 4; s++) step(1'b1, 8'(8'h20 + s), 1'b1);
      tests++; if (b_data !== 32'h23222120 || b_last !== 1'b0) begin
         fails++; $display("FAIL line_restart: got %h/%b want 23222120/0", b_data, b_last); end
   endtask

   task automatic test_gapped();
      do_reset();
      for (int s = 0; s < 4; s++) begin
         step(1'b1, 8'(s + 1), 1'b1);
         if (s < 3) begin
            for (int g = 0; g < 3; g++) begin
               step(1'b0, 8'hEE, 1'b1);
               tests++; if (a_valid !== 1'b0) begin fails++; $display("FAIL gap_valid: got %b want 0", a_valid); end
            end
         end
      end
      tests++; if (a_valid !== 1'b1 || a_data !== 32'h04030201) begin
         fails++; $display("FAIL gap_word: got %b/%h want 1/04030201", a_valid, a_data); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int s = 0; s < 20; s++) begin
         step(1'b1, 8'(s + 1), 1'b0);
         if (s == 15) begin
            tests++; if (a_level !== 3'd4 || a_ovf !== 1'b0) begin
               fails++; $display("FAIL ovf_full: got level %0d ovf %b want 4/0", a_level, a_ovf); end
         end
      end
      tests++; if (a_level !== 3'd4 || a_ovf !== 1'b1) begin
         fails++; $display("FAIL ovf_drop: got level %0d ovf %b want 4/1", a_level, a_ovf); end
      for (int k = 0; k < 4; k++) begin
         tests++; if (a_valid !== 1'b1 || a_data !== seq_word(4*k + 1)) begin
            fails++; $display("FAIL ovf_drain: got %b/%h want 1/%h", a_valid, a_data, seq_word(4*k + 1)); end
         step(1'b0, 8'h00, 1'b1);
      end
      tests++; if (a_valid !== 1'b0 || a_ovf !== 1'b1 || a_level !== 3'd0) begin
         fails++; $display("FAIL ovf_sticky: got %b/%b/%0d want 0/1/0", a_valid, a_ovf, a_level); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int s = 0; s < 19; s++) step(1'b1, 8'(s + 1), 1'b0);
      step(1'b1, 8'd20, 1'b1);
      tests++; if (a_level !== 3'd4 || a_ovf !== 1'b0) begin
         fails++; $display("FAIL fullpop_level: got %0d/%b want 4/0", a_level, a_ovf); end
      for (int k = 1; k < 5; k++) begin
         tests++; if (a_valid !== 1'b1 || a_data !== seq_word(4*k + 1)) begin
            fails++; $display("FAIL fullpop_order: got %b/%h want 1/%h", a_valid, a_data, seq_word(4*k + 1)); end
         step(1'b0, 8'h00, 1'b1);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int s = 0; s < 22; s++) step(1'b1, 8'(s + 1), 1'b0);
      ASYNCRESET = 1'b1;
      #1;
      tests++; if (a_valid !== 1'b0 || a_ovf !== 1'b0 || a_level !== 3'd0) begin
         fails++; $display("FAIL areset_now: got %b/%b/%0d want 0/0/0", a_valid, a_ovf, a_level); end
      #1;
      ASYNCRESET = 1'b0;
      model_reset();
      for (int s = 0; s < 4; s++) step(1'b1, 8'(8'hA0 + s), 1'b1);
      tests++; if (a_valid !== 1'b1 || a_data !== 32'hA3A2A1A0 || a_last !== 1'b0) begin
         fails++; $display("FAIL areset_word: got %b/%h/%b want 1/a3a2a1a0/0", a_valid, a_data, a_last); end
   endtask

   task automatic test_random();
      logic [32:0] ha, hb;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
         ha = qhead(0);
         hb = qhead(1);
         tests++; if (a_valid !== (qsize(0) > 0) || a_level !== 3'(qsize(0)) || a_ovf !== m_ovf[0]) begin
            fails++; $display("FAIL rand_a_ctl c%0d: got %b/%0d/%b want %b/%0d/%b", c, a_valid, a_level, a_ovf, qsize(0) > 0, qsize(0), m_ovf[0]); end
         tests++; if ({a_last, a_data} !== ha) begin
            fails++; $display("FAIL rand_a_word c%0d: got %h want %h", c, {a_last, a_data}, ha); end
         tests++; if (b_valid !== (qsize(1) > 0) || b_level !== 3'(qsize(1)) || b_ovf !== m_ovf[1]) begin
            fails++; $display("FAIL rand_b_ctl c%0d: got %b/%0d/%b want %b/%0d/%b", c, b_valid, b_level, b_ovf, qsize(1) > 0, qsize(1), m_ovf[1]); end
         tests++; if ({b_last, b_data} !== hb) begin
            fails++; $display("FAIL rand_b_word c%0d: got %h want %h", c, {b_last, b_data}, hb); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_line_end();
      test_gapped();
      test_overflow();
      test_full_pop();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
